// File: rtl/spi_master_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_arb: round-robin arbiter sharing one SPI mode-3 master among NREQ
// byte-stream requesters; CS held across multi-byte transactions. Rev 1.0
// ---------------------------------------------------------------------------
module spi_master_arb #(
  parameter int NREQ     = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              rsp_valid_o,
  output logic [7:0]        rsp_data_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic              busy_o,
  output logic              spi_clk_o,
  output logic              spi_mosi_o,
  output logic              spi_cs_o,
  input  logic              spi_miso_i
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     tx_q, tx_d;
  logic [7:0]     rx_q, rx_d;
  logic           last_q, last_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic           cs_q, cs_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] rot;
  logic            arb_hit;
  logic [IDW-1:0]  arb_idx;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_last;

  // Rotate valids so bit 0 is the requester at the RR pointer.
  always_comb begin
    rot     = NREQ'({req_valid_i, req_valid_i} >> ptr_q);
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_hit && rot[k]) begin
        arb_hit = 1'b1;
        arb_idx = (int'(ptr_q) + k >= NREQ) ? IDW'(int'(ptr_q) + k - NREQ)
                                            : IDW'(int'(ptr_q) + k);
      end
    end
  end

  always_comb begin
    sel_valid   = 1'b0;
    sel_data    = '0;
    sel_last    = 1'b0;
    req_ready_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q == IDW'(k)) begin
        sel_valid      = req_valid_i[k];
        sel_data       = req_data_i[8*k +: 8];
        sel_last       = req_last_i[k];
        req_ready_o[k] = (state_q == LOAD);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    last_d      = last_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_d        = cs_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          gnt_d   = arb_idx;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD: begin
        // First SCLK fall coincides with capture; MSB is already on MOSI.
        if (sel_valid) begin
          tx_d    = {sel_data[6:0], 1'b0};
          mosi_d  = sel_data[7];
          last_d  = sel_last;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != CW'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso_i};
          end else if (bit_q == 3'd7) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
            rsp_id_d    = gnt_q;
            state_d     = last_q ? HOLD : LOAD;
          end else begin
            bit_d  = bit_q + 3'd1;
            sclk_d = 1'b0;
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b0;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cs_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = (state_q != IDLE);
  assign spi_clk_o   = sclk_q;
  assign spi_mosi_o  = mosi_q;
  assign spi_cs_o    = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// tb_spi_master_arb: directed bench for spi_master_arb with a mode-3 slave model;
// u_dut0 uses CLK_DIV=4/CS_SETUP=2, u_dut1 uses CLK_DIV=1/CS_SETUP=1.
module tb_spi_master_arb;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, busy, sclk, mosi, cs;
  logic [7:0]  rsp_data;
  logic        miso = 1'b0;

  logic [1:0]  v1_valid = '0;
  logic [15:0] v1_data  = '0;
  logic [1:0]  v1_last  = '0;
  logic [1:0]  v1_ready;
  logic        v1_rsp_valid, v1_rsp_id, v1_busy, v1_sclk, v1_mosi, v1_cs;
  logic [7:0]  v1_rsp_data;
  logic        v1_miso = 1'b0;

  spi_master_arb #(.NREQ(2), .CLK_DIV(4), .CS_SETUP(2)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_id_o(rsp_id), .busy_o(busy), .spi_clk_o(sclk), .spi_mosi_o(mosi),
    .spi_cs_o(cs), .spi_miso_i(miso)
  );

  spi_master_arb #(.NREQ(2), .CLK_DIV(1), .CS_SETUP(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid_i(v1_valid), .req_data_i(v1_data), .req_last_i(v1_last),
    .req_ready_o(v1_ready), .rsp_valid_o(v1_rsp_valid), .rsp_data_o(v1_rsp_data),
    .rsp_id_o(v1_rsp_id), .busy_o(v1_busy), .spi_clk_o(v1_sclk), .spi_mosi_o(v1_mosi),
    .spi_cs_o(v1_cs), .spi_miso_i(v1_miso)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // Slave model for u_dut0: shifts on SCLK fall, MSB first, one response byte per byte slot.
  logic [7:0]  slv_rsp [0:3];
  int          nr0 = 0;
  logic [31:0] mosi_sh0 = '0;
  always @(negedge cs) begin
    nr0  = 0;
    miso = slv_rsp[0][7];
  end
  always @(posedge sclk) if (!cs) begin
    nr0++;
    mosi_sh0 = {mosi_sh0[30:0], mosi};
  end
  always @(negedge sclk) if (!cs && nr0 > 0 && nr0 < 32) miso = slv_rsp[nr0/8][7 - nr0%8];

  // Slave model for u_dut1.
  logic [7:0] rsp1 = 8'h3C;
  logic [7:0] mo1  = '0;
  int         nr1  = 0;
  always @(negedge v1_cs) begin
    nr1     = 0;
    v1_miso = rsp1[7];
  end
  always @(posedge v1_sclk) if (!v1_cs) begin
    nr1++;
    mo1 = {mo1[6:0], v1_mosi};
  end
  always @(negedge v1_sclk) if (!v1_cs && nr1 > 0 && nr1 < 8) v1_miso = rsp1[7 - nr1];

  typedef struct {
    logic [7:0] data;
    logic       id;
    logic [7:0] mo;
    int         cyc;
  } rsp_t;
  rsp_t rq[$];
  int   runs[$];
  int   cs_low_run = 0, cs_high_run = 0, last_gap = 0;
  int   v1_cnt = 0, v1_rcyc = 0, tog1 = 0;
  logic [7:0] v1_rdata = '0;
  logic v1_rid = 1'b0;
  logic sclk1_prev = 1'b1;

  always @(negedge sys_clk) begin
    if (rsp_valid) rq.push_back('{rsp_data, rsp_id, mosi_sh0[7:0], cyc});
    if (cs === 1'b0) begin
      if (cs_high_run > 0) last_gap = cs_high_run;
      cs_high_run = 0;
      cs_low_run++;
    end else begin
      if (cs_low_run > 0) runs.push_back(cs_low_run);
      cs_low_run = 0;
      cs_high_run++;
    end
    if (v1_rsp_valid) begin
      v1_cnt++;
      v1_rcyc  = cyc;
      v1_rdata = v1_rsp_data;
      v1_rid   = v1_rsp_id;
    end
    if (v1_sclk !== sclk1_prev) tog1++;
    sclk1_prev = v1_sclk;
  end

  int n_chk = 0, n_pass = 0;
  int rdy_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one byte on requester i; returns at the negedge after it is accepted.
  task automatic xfer(input int i, input logic [7:0] d, input logic l);
    int w;
    w = 0;
    req_valid[i]       = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
    while (!req_ready[i] && w < 3000) begin
      @(negedge sys_clk);
      w++;
    end
    check("xfer_ready", {31'd0, req_ready[i]}, 32'd1);
    rdy_cyc = cyc;
    @(negedge sys_clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge sys_clk);
    while (busy && w < 5000) begin
      @(negedge sys_clk);
      w++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base, w, bad, r0;
    slv_rsp[0] = 8'h3C; slv_rsp[1] = 8'h00; slv_rsp[2] = 8'h00; slv_rsp[3] = 8'h00;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_cs",       {31'd0, cs},        32'd1);
    check("rst_sclk",     {31'd0, sclk},      32'd1);
    check("rst_mosi",     {31'd0, mosi},      32'd0);
    check("rst_ready",    {30'd0, req_ready}, 32'd0);
    check("rst_rsp_v",    {31'd0, rsp_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},      32'd0);
    check("rst_rsp_data", {24'd0, rsp_data},  32'd0);
    check("rst_rsp_id",   {31'd0, rsp_id},    32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Test 1: single byte 0xA5 from req0, slave answers 0x3C.
    rq.delete(); runs.delete();
    base = cyc;
    xfer(0, 8'hA5, 1'b1);
    check("t1_ready_cyc", rdy_cyc - base, 32'd3);
    wait_idle();
    check("t1_rsp_cnt", rq.size(), 32'd1);
    if (rq.size() == 1) begin
      check("t1_rsp_data", {24'd0, rq[0].data}, 32'h3C);
      check("t1_rsp_id",   {31'd0, rq[0].id},   32'd0);
      check("t1_mosi",     {24'd0, rq[0].mo},   32'hA5);
      check("t1_rsp_cyc",  rq[0].cyc - base,    32'd68);
    end
    check("t1_sclk_rises", nr0, 32'd8);
    check("t1_cs_low", (runs.size() > 0) ? runs[0] : -1, 32'd69);

    // Test 2: both requesters valid after reset; round-robin order and CS gap.
    do_reset();
    rq.delete();
    slv_rsp[0] = 8'h96;
    fork
      xfer(0, 8'h11, 1'b1);
      xfer(1, 8'h22, 1'b1);
    join
    wait_idle();
    check("t2_cs_gap", {31'd0, last_gap >= 1}, 32'd1);
    fork
      xfer(0, 8'h11, 1'b1);
      xfer(1, 8'h22, 1'b1);
    join
    wait_idle();
    check("t2_rsp_cnt", rq.size(), 32'd4);
    if (rq.size() == 4) begin
      check("t2_id0",   {31'd0, rq[0].id},   32'd0);
      check("t2_mo0",   {24'd0, rq[0].mo},   32'h11);
      check("t2_id1",   {31'd0, rq[1].id},   32'd1);
      check("t2_mo1",   {24'd0, rq[1].mo},   32'h22);
      check("t2_data1", {24'd0, rq[1].data}, 32'h96);
      check("t2_rep_id0", {31'd0, rq[2].id}, 32'd0);
      check("t2_rep_id1", {31'd0, rq[3].id}, 32'd1);
    end

    // Test 3: 3-byte transaction on req1 while req0 waits.
    rq.delete(); runs.delete();
    slv_rsp[0] = 8'hC3; slv_rsp[1] = 8'h81; slv_rsp[2] = 8'h7E;
    bad = 0;
    fork
      begin
        xfer(1, 8'hD1, 1'b0);
        xfer(1, 8'hD2, 1'b0);
        xfer(1, 8'hD3, 1'b1);
      end
      begin
        w = 0;
        @(negedge sys_clk);
        while (!busy && w < 100) begin
          @(negedge sys_clk);
          w++;
        end
        req_valid[0] = 1'b1; req_data[7:0] = 8'h44; req_last[0] = 1'b1;
        @(negedge sys_clk);
        w = 0;
        while (!cs && w < 1000) begin
          if (req_ready[0]) bad++;
          @(negedge sys_clk);
          w++;
        end
        check("t3_r0_blocked", bad, 32'd0);
        xfer(0, 8'h44, 1'b1);
      end
    join
    wait_idle();
    check("t3_rsp_cnt", rq.size(), 32'd4);
    if (rq.size() == 4) begin
      check("t3_id_a",   {31'd0, rq[0].id},   32'd1);
      check("t3_id_b",   {31'd0, rq[1].id},   32'd1);
      check("t3_id_c",   {31'd0, rq[2].id},   32'd1);
      check("t3_data_a", {24'd0, rq[0].data}, 32'hC3);
      check("t3_data_b", {24'd0, rq[1].data}, 32'h81);
      check("t3_data_c", {24'd0, rq[2].data}, 32'h7E);
      check("t3_mo_c",   {24'd0, rq[2].mo},   32'hD3);
      check("t3_id_r0",  {31'd0, rq[3].id},   32'd0);
    end
    check("t3_cs_low", (runs.size() > 0) ? runs[0] : -1, 32'd199);

    // Test 4: requester stalls 20 cycles between bytes.
    rq.delete();
    slv_rsp[0] = 8'h5A; slv_rsp[1] = 8'hE7;
    xfer(0, 8'h6B, 1'b0);
    w = 0;
    while (!req_ready[0] && w < 200) begin
      @(negedge sys_clk);
      w++;
    end
    check("t4_in_load", {31'd0, req_ready[0]}, 32'd1);
    bad = 0;
    r0  = nr0;
    repeat (20) begin
      @(negedge sys_clk);
      if (cs !== 1'b0 || sclk !== 1'b1) bad++;
    end
    check("t4_stall_bus", bad, 32'd0);
    check("t4_stall_edges", nr0 - r0, 32'd0);
    xfer(0, 8'h9C, 1'b1);
    wait_idle();
    check("t4_rsp_cnt", rq.size(), 32'd2);
    if (rq.size() == 2) begin
      check("t4_data_a", {24'd0, rq[0].data}, 32'h5A);
      check("t4_data_b", {24'd0, rq[1].data}, 32'hE7);
      check("t4_mo_b",   {24'd0, rq[1].mo},   32'h9C);
    end

    // Test 5: reset in the low half of bit 4.
    rq.delete();
    xfer(0, 8'hF0, 1'b1);
    w = 0;
    while (nr0 < 4 && w < 200) begin
      @(negedge sys_clk);
      w++;
    end
    repeat (6) @(negedge sys_clk);
    check("t5_mid_byte", {31'd0, sclk}, 32'd0);
    sys_rst_n = 1'b0;
    req_valid = '0;
    @(negedge sys_clk);
    check("t5_cs",    {31'd0, cs},        32'd1);
    check("t5_sclk",  {31'd0, sclk},      32'd1);
    check("t5_mosi",  {31'd0, mosi},      32'd0);
    check("t5_ready", {30'd0, req_ready}, 32'd0);
    check("t5_busy",  {31'd0, busy},      32'd0);
    check("t5_rsp_v", {31'd0, rsp_valid}, 32'd0);
    sys_rst_n = 1'b1;
    r0 = nr0;
    repeat (100) @(negedge sys_clk);
    check("t5_no_rsp",  rq.size(), 32'd0);
    check("t5_no_sclk", nr0 - r0,  32'd0);

    // Test 6: fastest settings on u_dut1.
    tog1 = 0;
    base = cyc;
    v1_valid[0] = 1'b1; v1_data[7:0] = 8'hA5; v1_last[0] = 1'b1;
    w = 0;
    while (!v1_ready[0] && w < 100) begin
      @(negedge sys_clk);
      w++;
    end
    check("t6_ready_cyc", cyc - base, 32'd2);
    @(negedge sys_clk);
    v1_valid = '0;
    w = 0;
    while (v1_busy && w < 200) begin
      @(negedge sys_clk);
      w++;
    end
    repeat (2) @(negedge sys_clk);
    check("t6_rsp_cnt",  v1_cnt,           32'd1);
    check("t6_rsp_cyc",  v1_rcyc - base,   32'd19);
    check("t6_rsp_data", {24'd0, v1_rdata}, 32'h3C);
    check("t6_rsp_id",   {31'd0, v1_rid},   32'd0);
    check("t6_mosi",     {24'd0, mo1},      32'hA5);
    check("t6_toggles",  tog1,              32'd16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
